iter_div: RTL and testbench
===========================

ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width; legal range 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 a  input  WIDTH  unsigned dividend, captured on accepted start.
REQ-006 b  input  WIDTH  unsigned divisor, captured on accepted start.
REQ-007 busy  output  1  high in RUN and DONE states.
REQ-008 done  output  1  one-cycle pulse; q/r valid in that cycle.
REQ-009 q  output  WIDTH  quotient, registered.
REQ-010 r  output  WIDTH  remainder, registered.
REQ-011 dz  output  1  divide-by-zero flag; present only with DIV_ZERO_CHECK_EN.

Function
REQ-012 The block SHALL implement restoring unsigned division, one quotient bit per clock, MSB first.
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE + start=1 SHALL capture a into the quotient/shift register, b into the divisor register, clear the partial remainder, load the counter with WIDTH, and go to RUN.
REQ-015 Each RUN cycle SHALL shift {rem,qreg} left by one, trial-subtract b from rem (WIDTH+1-bit difference), keep the difference and set the qreg LSB to 1 if non-negative, else restore and set it to 0, then decrement the counter.
REQ-016 RUN SHALL go to DONE in the cycle the counter reaches 0; DONE SHALL last exactly one cycle and return to IDLE.
REQ-017 Latency: done SHALL be high exactly WIDTH+1 clock edges after the edge that accepted start.
REQ-018 q and r SHALL update only at the RUN->DONE edge and hold their values until the next result is written.
REQ-019 start SHALL be ignored while busy=1; a back-to-back start in the DONE cycle is also ignored; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-020 a < b SHALL yield q=0, r=a; b=1 SHALL yield q=a, r=0.
REQ-021 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap.

Reset
REQ-022 clrn=0 SHALL immediately force state IDLE, busy=0, done=0, q=0, r=0, dz=0, and clear all internal registers, including mid-RUN.
REQ-023 The first start after clrn deasserts SHALL be accepted normally; no partial result from an aborted operation SHALL appear.

Configuration
REQ-024 Macro DIV_ZERO_CHECK_EN defined: b=0 at accepted start SHALL skip RUN and go directly to DONE next cycle, with q=all ones, r=a, dz=1; dz SHALL be cleared at the next accepted start.
REQ-025 Macro DIV_ZERO_CHECK_EN undefined: no dz port; b=0 SHALL run the full WIDTH cycles and yield q=all ones, r=a.

Structure
REQ-026 Package div_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default-width constant.
REQ-027 The quotient shift register SHALL be sub-module div_qreg: parameter WIDTH, with a load/shift mux (load a when load=1, else shift left inserting the quotient bit), and asynchronous active-low clear.

Verification
REQ-028 WIDTH=32, a=100, b=7, start pulse -> done exactly 33 cycles later, q=14, r=2, busy high for 33 cycles.
REQ-029 a=5, b=9 -> q=0, r=5; a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0.
REQ-030 b=0 with DIV_ZERO_CHECK_EN -> done 1 cycle after start, q=0xFFFFFFFF, r=a, dz=1; without it -> done after 33 cycles, same q/r.
REQ-031 start re-pulsed at cycles 5 and 33 (DONE cycle) with other operands -> both ignored, first result unchanged; start at cycle 34 -> accepted.
REQ-032 clrn pulsed low at cycle 10 of RUN -> outputs 0 at once, FSM IDLE; next operation 1000/10 -> q=100, r=0.
REQ-033 WIDTH=8, random a,b (b!=0), 500 runs -> q*b+r==a and r<b every run.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding, default
// operand width and the counter-width helper.
package div_pkg;

    // Default operand/quotient/remainder width
    localparam int unsigned DEF_WIDTH = 32;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Bits needed to hold the value w (counter loads WIDTH and counts to 0)
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_qreg.sv
// Quotient shift register: loads the dividend on start, then shifts left one
// bit per iteration while inserting the freshly computed quotient bit.
module div_qreg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a,
    input  logic             qbit,
    output logic [WIDTH-1:0] qreg
);

    // Load has priority over shift; the MSB shifted out feeds the remainder
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            qreg <= '0;
        end else if (load) begin
            qreg <= a;
        end else if (shift) begin
            qreg <= {qreg[WIDTH-2:0], qbit};
        end
    end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring unsigned divider, one quotient bit per clock, MSB first.
// Optional feature macro: DIV_ZERO_CHECK_EN adds the dz port and a fast path
// that finishes a divide-by-zero in a single cycle.
module iter_div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
`ifdef DIV_ZERO_CHECK_EN
    ,
    output logic             dz
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] qreg;

    logic             load;
    logic             shift;
    logic             qbit;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] rem_nxt;
    logic             unused_trial;

    // One restoring step: shift dividend MSB into the remainder, trial-subtract
    always_comb begin
        load    = (state == IDLE) && start;
        shift   = (state == RUN);
        rem_sh  = {rem, qreg[WIDTH-1]};
        // Extra top bit gives a true borrow even when divisor is zero
        trial   = {1'b0, rem_sh} - {2'b00, divisor};
        qbit    = ~trial[WIDTH+1];
        rem_nxt = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

    // Bit WIDTH of the trial is implied zero whenever the subtraction succeeds
    assign unused_trial = trial[WIDTH];

    div_qreg #(
        .WIDTH (WIDTH)
    ) u_qreg (
        .clk   (clk),
        .clrn  (clrn),
        .load  (load),
        .shift (shift),
        .a     (a),
        .qbit  (qbit),
        .qreg  (qreg)
    );

    // Control FSM with registered busy/done and result registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            divisor <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            r       <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dz      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        divisor <= b;
                        rem     <= '0;
                        cnt     <= CW'(WIDTH);
                        busy    <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                        if (b == '0) begin
                            // Result is known immediately; skip iterating
                            state <= DONE;
                            done  <= 1'b1;
                            q     <= '1;
                            r     <= a;
                            dz    <= 1'b1;
                        end else begin
                            state <= RUN;
                            dz    <= 1'b0;
                        end
`else
                        state   <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                    // Last bit: publish the result in the same edge
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        q     <= {qreg[WIDTH-2:0], qbit};
                        r     <= rem_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: transaction-level model (plain division
// and a latency countdown) compared every cycle, plus literal spot checks.
module tb_iter_div;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          start32 = 1'b0;
    logic [W-1:0]  a32 = '0;
    logic [W-1:0]  b32 = '0;
    logic          busy32, done32;
    logic [W-1:0]  q32, r32;
    logic          start8 = 1'b0;
    logic [7:0]    a8 = '0;
    logic [7:0]    b8 = '0;
    logic          busy8, done8;
    logic [7:0]    q8, r8;
`ifdef DIV_ZERO_CHECK_EN
    logic          dz32, dz8;
`endif

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    iter_div #(.WIDTH(W)) dut32 (
        .clk   (clk),
        .clrn  (clrn),
        .start (start32),
        .a     (a32),
        .b     (b32),
        .busy  (busy32),
        .done  (done32),
        .q     (q32),
        .r     (r32)
`ifdef DIV_ZERO_CHECK_EN
        ,
        .dz    (dz32)
`endif
    );

    iter_div #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .clrn  (clrn),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .q     (q8),
        .r     (r8)
`ifdef DIV_ZERO_CHECK_EN
        ,
        .dz    (dz8)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_q(input logic [63:0] x, input logic [63:0] y,
                                          input int w);
        if (y == 0) return (64'd1 << w) - 64'd1;
        return x / y;
    endfunction

    function automatic logic [63:0] ref_r(input logic [63:0] x, input logic [63:0] y);
        if (y == 0) return x;
        return x % y;
    endfunction

    // Transaction model of the 32-bit divider
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dz = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic [W-1:0] m_pq = '0;
    logic [W-1:0] m_pr = '0;
    int           m_left = 0;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_left <= 0;
        end else if (!m_busy) begin
            if (start32) begin
                m_busy <= 1'b1;
                m_pq   <= W'(ref_q(64'(a32), 64'(b32), W));
                m_pr   <= W'(ref_r(64'(a32), 64'(b32)));
                m_left <= W;
`ifdef DIV_ZERO_CHECK_EN
                m_dz   <= (b32 == '0);
                if (b32 == '0) begin
                    m_done <= 1'b1;
                    m_q    <= '1;
                    m_r    <= a32;
                end
`endif
            end
        end else if (m_done) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_q    <= m_pq;
                m_r    <= m_pr;
            end
        end
    end

    // Every-cycle comparison of the 32-bit DUT against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 64'(busy32), 64'(m_busy));
            chk("done", 64'(done32), 64'(m_done));
            chk("q", 64'(q32), 64'(m_q));
            chk("r", 64'(r32), 64'(m_r));
`ifdef DIV_ZERO_CHECK_EN
            chk("dz", 64'(dz32), 64'(m_dz));
`endif
        end
    end

    // Start one 32-bit division in the next cycle and wait (bounded) for done
    task automatic run32(input logic [W-1:0] x, input logic [W-1:0] y, output int lat,
                         output int bc, output logic [W-1:0] qo, output logic [W-1:0] ro);
        lat = 0;
        bc = 0;
        qo = '0;
        ro = '0;
        @(negedge clk);
        start32 = 1'b1;
        a32 = x;
        b32 = y;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (busy32) bc++;
            if (done32) begin
                lat = k;
                qo = q32;
                ro = r32;
                break;
            end
        end
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y);
        int lat;
        lat = 0;
        @(negedge clk);
        start8 = 1'b1;
        a8 = x;
        b8 = y;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                lat = k;
                break;
            end
        end
        chk("lat8", 64'(lat), 64'd9);
        chk("busy8", 64'(busy8), 64'd1);
        chk("q8", 64'(q8), ref_q(64'(x), 64'(y), 8));
        chk("r8", 64'(r8), ref_r(64'(x), 64'(y)));
        chk("qbr8", 64'(int'(q8) * int'(y) + int'(r8)), 64'(x));
        chk("rltb8", 64'(r8 < y), 64'd1);
`ifdef DIV_ZERO_CHECK_EN
        chk("dz8", 64'(dz8), 64'd0);
`endif
    endtask

    initial begin
        int lat, bc, exp_lat;
        logic [W-1:0] qo, ro, x, y;
        int sel;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_q", 64'(q32), 64'd0);
        chk("rst_r", 64'(r32), 64'd0);
        clrn = 1'b1;
        cmp_en = 1'b1;

        // 100 / 7
        run32(32'd100, 32'd7, lat, bc, qo, ro);
        chk("lat_100_7", 64'(lat), 64'd33);
        chk("busy_cycles", 64'(bc), 64'd33);
        chk("q_100_7", 64'(qo), 64'd14);
        chk("r_100_7", 64'(ro), 64'd2);

        run32(32'd5, 32'd9, lat, bc, qo, ro);
        chk("q_5_9", 64'(qo), 64'd0);
        chk("r_5_9", 64'(ro), 64'd5);

        run32(32'hFFFF_FFFF, 32'd1, lat, bc, qo, ro);
        chk("q_max_1", 64'(qo), 64'hFFFF_FFFF);
        chk("r_max_1", 64'(ro), 64'd0);

        run32(32'd1234, 32'd0, lat, bc, qo, ro);
`ifdef DIV_ZERO_CHECK_EN
        chk("lat_dz", 64'(lat), 64'd1);
        chk("dz_flag", 64'(dz32), 64'd1);
`else
        chk("lat_dz", 64'(lat), 64'd33);
`endif
        chk("q_dz", 64'(qo), 64'hFFFF_FFFF);
        chk("r_dz", 64'(ro), 64'd1234);

        // Starts during RUN and DONE are ignored; the first IDLE start is taken
        @(negedge clk);
        start32 = 1'b1;
        a32 = 32'd100;
        b32 = 32'd7;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            start32 = (k == 5 || k == 33 || k == 34);
            if (k == 5) begin
                a32 = 32'd50;
                b32 = 32'd3;
            end
            if (k == 33) begin
                chk("ign_done", 64'(done32), 64'd1);
                chk("ign_q", 64'(q32), 64'd14);
                chk("ign_r", 64'(r32), 64'd2);
                a32 = 32'd77;
                b32 = 32'd5;
            end
        end
        lat = 0;
        for (int k = 35; k <= 100; k++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (done32) begin
                lat = k;
                break;
            end
        end
        chk("lat_restart", 64'(lat), 64'd67);
        chk("q_77_5", 64'(q32), 64'd15);
        chk("r_77_5", 64'(r32), 64'd2);

        // Reset in the middle of a run
        @(negedge clk);
        start32 = 1'b1;
        a32 = 32'd12345;
        b32 = 32'd67;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        clrn = 1'b0;
        #1;
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_done", 64'(done32), 64'd0);
        chk("abort_q", 64'(q32), 64'd0);
        chk("abort_r", 64'(r32), 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        run32(32'd1000, 32'd10, lat, bc, qo, ro);
        chk("lat_1000_10", 64'(lat), 64'd33);
        chk("q_1000_10", 64'(qo), 64'd100);
        chk("r_1000_10", 64'(ro), 64'd0);

        // Randomised 32-bit runs over distinct operand classes
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 4);
            x = $urandom;
            case (sel)
                0: y = $urandom;
                1: begin
                    y = $urandom | 32'h0000_1000;
                    x = x % y;
                end
                2: y = 32'd1;
                3: y = 32'd0;
                default: y = $urandom_range(1, 16);
            endcase
`ifdef DIV_ZERO_CHECK_EN
            exp_lat = (y == 0) ? 1 : 33;
`else
            exp_lat = 33;
`endif
            run32(x, y, lat, bc, qo, ro);
            chk("lat_rand", 64'(lat), 64'(exp_lat));
        end

        // Randomised 8-bit runs
        for (int i = 0; i < 500; i++) begin
            run8(8'($urandom), 8'($urandom_range(1, 255)));
        end

        cmp_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
